// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port, variable-latency memory between the fetch port and the data port.
// Data wins ties, but after MAX_DSTREAK consecutive data grants with IF waiting, IF is forced in.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_inst,
  output logic          if_stall,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_adr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        state_q, state_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_adr_q, mem_adr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_inst_q, if_inst_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [SW-1:0] streak_q, streak_d;

  logic dreq, ireq, force_if;

  // A port in its done cycle is released, so it must not be re-granted.
  assign dreq     = (dm_read | dm_write) & ~dm_done_q;
  assign ireq     = if_req & ~if_done_q;
  assign force_if = ireq & (streak_q == SMAX);

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_adr_d   = mem_adr_q;
    mem_wdata_d = mem_wdata_q;
    if_inst_d   = if_inst_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    streak_d    = streak_q;
    case (state_q)
      IDLE: begin
        if (dreq && !force_if) begin
          state_d     = SERVE_D;
          mem_adr_d   = dm_adr;
          mem_wdata_d = dm_wdata;
          mem_we_d    = dm_write;
          if (!if_req)              streak_d = '0;
          else if (streak_q != SMAX) streak_d = streak_q + SW'(1);
        end else if (ireq) begin
          state_d   = SERVE_I;
          mem_adr_d = if_adr;
          mem_we_d  = 1'b0;
          streak_d  = '0;
        end
      end
      SERVE_I: begin
        if (mem_ack) begin
          state_d   = IDLE;
          if_done_d = 1'b1;
          if_inst_d = mem_rdata;
        end
      end
      SERVE_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          dm_done_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      if_inst_q   <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      if_inst_q   <= if_inst_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      streak_q    <= streak_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_inst   = if_inst_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = ireq;
  assign dm_stall  = dreq;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: cycle table for fetch/data basics, hand sequences for write, streak limit and reset.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_stall, dm_read, dm_write, dm_stall;
  logic [31:0] if_adr, if_inst, dm_adr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_inst(if_inst), .if_stall(if_stall),
    .dm_read(dm_read), .dm_write(dm_write), .dm_adr(dm_adr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq;
    logic [31:0] iadr;
    logic        drd;
    logic [31:0] dadr;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_adr;
    logic        e_ist, e_dst;
    logic [31:0] e_inst, e_drd;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; if_adr = '0; dm_read = 1'b0; dm_write = 1'b0;
    dm_adr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();

    // rst ireq iadr drd dadr ack rdata | req we adr ist dst inst drd
    vq.push_back('{1,1,32'h10,0,32'h0, 0,32'h0,       0,0,32'h0, 1,0,32'h0,       32'h0});
    vq.push_back('{1,1,32'h10,0,32'h0, 0,32'h0,       1,0,32'h10,1,0,32'h0,       32'h0});
    vq.push_back('{1,1,32'h10,0,32'h0, 1,32'h2002000A,1,0,32'h10,1,0,32'h0,       32'h0});
    vq.push_back('{1,1,32'h10,0,32'h0, 0,32'h0,       0,0,32'h10,0,0,32'h2002000A,32'h0});
    vq.push_back('{1,0,32'h0, 0,32'h0, 0,32'h0,       0,0,32'h10,0,0,32'h2002000A,32'h0});
    vq.push_back('{1,1,32'h14,1,32'h40,0,32'h0,       0,0,32'h10,1,1,32'h2002000A,32'h0});
    vq.push_back('{1,1,32'h14,1,32'h40,0,32'h0,       1,0,32'h40,1,1,32'h2002000A,32'h0});
    vq.push_back('{1,1,32'h14,1,32'h40,1,32'h11112222,1,0,32'h40,1,1,32'h2002000A,32'h0});
    vq.push_back('{1,1,32'h14,1,32'h40,0,32'h0,       0,0,32'h40,1,0,32'h2002000A,32'h11112222});
    vq.push_back('{1,1,32'h14,0,32'h0, 0,32'h0,       1,0,32'h14,1,0,32'h2002000A,32'h11112222});
    vq.push_back('{1,1,32'h14,0,32'h0, 1,32'h33334444,1,0,32'h14,1,0,32'h2002000A,32'h11112222});
    vq.push_back('{1,1,32'h14,0,32'h0, 0,32'h0,       0,0,32'h14,0,0,32'h33334444,32'h11112222});
    vq.push_back('{1,0,32'h0, 0,32'h0, 0,32'h0,       0,0,32'h14,0,0,32'h33334444,32'h11112222});
    // stray ack while idle
    vq.push_back('{1,0,32'h0, 0,32'h0, 1,32'hFFFFFFFF,0,0,32'h14,0,0,32'h33334444,32'h11112222});
    vq.push_back('{1,0,32'h0, 0,32'h0, 0,32'h0,       0,0,32'h14,0,0,32'h33334444,32'h11112222});

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; if_req = vq[i].ireq; if_adr = vq[i].iadr;
      dm_read = vq[i].drd; dm_adr = vq[i].dadr; mem_ack = vq[i].ack; mem_rdata = vq[i].rdata;
      #1;
      chk($sformatf("v%0d.mem_req", i),  32'(mem_req),  32'(vq[i].e_req));
      chk($sformatf("v%0d.busy", i),     32'(busy),     32'(vq[i].e_req));
      chk($sformatf("v%0d.mem_we", i),   32'(mem_we),   32'(vq[i].e_we));
      chk($sformatf("v%0d.mem_adr", i),  mem_adr,       vq[i].e_adr);
      chk($sformatf("v%0d.if_stall", i), 32'(if_stall), 32'(vq[i].e_ist));
      chk($sformatf("v%0d.dm_stall", i), 32'(dm_stall), 32'(vq[i].e_dst));
      chk($sformatf("v%0d.if_inst", i),  if_inst,       vq[i].e_inst);
      chk($sformatf("v%0d.dm_rdata", i), dm_rdata,      vq[i].e_drd);
      tick();
    end
    mem_ack = 1'b0;

    // store with a 3-cycle wait before ack
    dm_write = 1'b1; dm_adr = 32'h80; dm_wdata = 32'hDEADBEEF; #1;
    chk("wr.stall_req", 32'(dm_stall), 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("wr.c%0d.req", c),   32'(mem_req), 32'd1);
      chk($sformatf("wr.c%0d.we", c),    32'(mem_we),  32'd1);
      chk($sformatf("wr.c%0d.adr", c),   mem_adr,      32'h80);
      chk($sformatf("wr.c%0d.wdata", c), mem_wdata,    32'hDEADBEEF);
      chk($sformatf("wr.c%0d.stall", c), 32'(dm_stall), 32'd1);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 32'h55555555; #1;
    chk("wr.ack.stall", 32'(dm_stall), 32'd1);
    tick();
    mem_ack = 1'b0; #1;
    chk("wr.done.stall", 32'(dm_stall), 32'd0);
    chk("wr.done.busy",  32'(busy),     32'd0);
    chk("wr.rdata_hold", dm_rdata,      32'h11112222);
    tick();
    dm_write = 1'b0; dm_wdata = '0;
    tick();

    // streak: IF requests at every data grant; data keeps winning until the limit
    dm_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_req = 1'b1; if_adr = 32'h200; dm_adr = 32'h100 + 32'(k * 4); #1;
      chk($sformatf("st%0d.idle", k), 32'(mem_req), 32'd0);
      tick(); #1;
      chk($sformatf("st%0d.adr", k), mem_adr,      32'h100 + 32'(k * 4));
      chk($sformatf("st%0d.we", k),  32'(mem_we),  32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hA0000000 + 32'(k);
      tick();
      mem_ack = 1'b0; if_req = 1'b0; #1;
      chk($sformatf("st%0d.dstall", k), 32'(dm_stall), 32'd0);
      chk($sformatf("st%0d.rdata", k),  dm_rdata,      32'hA0000000 + 32'(k));
      tick();
    end
    if_req = 1'b1; dm_adr = 32'h110; #1;
    chk("st.both_pending", 32'({if_stall, dm_stall}), 32'd3);
    tick(); #1;
    chk("st.forced_if_adr", mem_adr,     32'h200);
    chk("st.forced_if_we",  32'(mem_we), 32'd0);
    chk("st.dm_waits",      32'(dm_stall), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hBBBB0000;
    tick();
    mem_ack = 1'b0; #1;
    chk("st.if_inst",  if_inst,        32'hBBBB0000);
    chk("st.if_stall", 32'(if_stall),  32'd0);
    tick(); #1;
    chk("st.data_resumes", mem_adr, 32'h110);
    chk("st.data_busy",    32'(busy), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCCCC0000;
    tick();
    mem_ack = 1'b0; if_req = 1'b0; dm_read = 1'b0;
    tick();

    // reset in the middle of a data access; the late ack must be ignored
    dm_read = 1'b1; dm_adr = 32'h300;
    tick(); #1;
    chk("rs.serving", 32'(mem_req), 32'd1);
    chk("rs.adr",     mem_adr,      32'h300);
    rst = 1'b0;
    tick();
    rst = 1'b1; dm_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777; #1;
    chk("rs.req",   32'(mem_req), 32'd0);
    chk("rs.busy",  32'(busy),    32'd0);
    chk("rs.adr0",  mem_adr,      32'h0);
    chk("rs.inst0", if_inst,      32'h0);
    chk("rs.drd0",  dm_rdata,     32'h0);
    tick(); #1;
    chk("rs.late_ack_busy", 32'(busy), 32'd0);
    chk("rs.late_ack_drd",  dm_rdata,  32'h0);
    mem_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
